// File: rtl/ble_telemetry_tx.sv
`default_nettype none
// ============================================================================
// Module   : ble_telemetry_tx
// Purpose  : Telemetry return path for the Bluetooth link. On a one-cycle
//            send pulse it snapshots NUM_BYTES payload bytes and serialises
//            them as 8N1, LSB first, followed by a 0x0A terminator. Any
//            payload byte equal to 0x0A is sent as 0x0B, so the receiver
//            never sees an early terminator.
// Optional : `define TELEM_CHECKSUM_EN inserts an XOR checksum byte between
//            the last payload byte and the terminator. The checksum covers
//            the bytes as transmitted, and 0x0A is also sent as 0x0B.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous reset, active low
//            send     - frame request, sampled every rising edge
//            payload  - bytes to send, payload[0] goes first
//            txd      - serial out to the BLE module UART RX, idle high
//            busy     - high while a frame is in flight
//            done     - one-cycle pulse when a frame completes
//            drop_cnt - saturating count of requests rejected while busy
// Revision : 1.0 - initial release
// ============================================================================
module ble_telemetry_tx #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD      = 115200,
   parameter int NUM_BYTES = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       send,
   input  logic [NUM_BYTES-1:0][7:0]  payload,
   output logic                       txd,
   output logic                       busy,
   output logic                       done,
   output logic [7:0]                 drop_cnt
);

   localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int c_CW = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;
`ifdef TELEM_CHECKSUM_EN
   localparam int c_LAST_IDX = NUM_BYTES + 1;   // payload, checksum, newline
`else
   localparam int c_LAST_IDX = NUM_BYTES;       // payload, newline
`endif
   localparam int c_IW = $clog2(c_LAST_IDX + 1);

   localparam logic [c_CW-1:0] c_CLK_LAST    = c_CW'(c_CLKS_PER_BIT - 1);
   localparam logic [c_IW-1:0] c_IDX_LAST    = c_IW'(c_LAST_IDX);
   localparam logic [c_IW-1:0] c_IDX_PAY_END = c_IW'(NUM_BYTES);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_START = 2'd1;
   localparam logic [1:0] c_DATA  = 2'd2;
   localparam logic [1:0] c_STOP  = 2'd3;

   logic [1:0]                r_state;
   logic [1:0]                w_next;
   logic [c_CW-1:0]           r_clk;
   logic [2:0]                r_bit;
   logic [c_IW-1:0]           r_idx;
   logic [7:0]                r_shift;
   logic [NUM_BYTES-1:0][7:0] r_snap;
   logic                      r_done;
   logic [7:0]                r_drop;

   logic                      w_bit_end;
   logic                      w_last_byte;
   logic                      w_accept;
   logic [NUM_BYTES-1:0][7:0] w_guarded;
   logic [7:0]                w_cur_byte;
   logic                      w_txd;
   logic                      w_busy;

   assign w_bit_end   = (r_clk == c_CLK_LAST);
   assign w_last_byte = (r_idx == c_IDX_LAST);
   assign w_accept    = (r_state == c_IDLE) && send;

   // Newline substitution is applied at snapshot time, so the stored bytes
   // are exactly what goes on the wire.
   always_comb begin
      w_guarded = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         w_guarded[i] = (payload[i] == 8'h0A) ? 8'h0B : payload[i];
      end
   end

`ifdef TELEM_CHECKSUM_EN
   logic [7:0] r_csum;
   logic [7:0] w_csum_raw;
   logic [7:0] w_csum;

   always_comb begin
      w_csum_raw = 8'h00;
      for (int i = 0; i < NUM_BYTES; i++) begin
         w_csum_raw = w_csum_raw ^ w_guarded[i];
      end
      w_csum = (w_csum_raw == 8'h0A) ? 8'h0B : w_csum_raw;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_csum <= 8'h00;
      end else if (w_accept) begin
         r_csum <= w_csum;
      end
   end
`endif

   // The snapshot shifts down one byte per transmitted byte, so the current
   // payload byte is always r_snap[0]; past the payload comes the optional
   // checksum and finally the terminator.
   always_comb begin
      w_cur_byte = 8'h0A;
      if (r_idx < c_IDX_PAY_END) begin
         w_cur_byte = r_snap[0];
      end
`ifdef TELEM_CHECKSUM_EN
      else if (r_idx == c_IDX_PAY_END) begin
         w_cur_byte = r_csum;
      end
`endif
   end

   // ---------------------------------------------------------------- FSM --
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (send)                     w_next = c_START;
         c_START: if (w_bit_end)                w_next = c_DATA;
         c_DATA:  if (w_bit_end && r_bit == 3'd7) w_next = c_STOP;
         c_STOP:  if (w_bit_end)                w_next = w_last_byte ? c_IDLE : c_START;
         default:                               w_next = c_IDLE;
      endcase
   end

   always_comb begin
      w_txd  = 1'b1;
      w_busy = 1'b1;
      case (r_state)
         c_IDLE:  w_busy = 1'b0;
         c_START: w_txd  = 1'b0;
         c_DATA:  w_txd  = r_shift[0];
         c_STOP:  w_txd  = 1'b1;
         default: w_busy = 1'b0;
      endcase
   end

   // ----------------------------------------------------------- datapath --
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk   <= '0;
         r_bit   <= 3'd0;
         r_idx   <= '0;
         r_shift <= 8'hFF;
         r_snap  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= (r_state == c_STOP) && w_bit_end && w_last_byte;

         if (r_state == c_IDLE || w_bit_end) begin
            r_clk <= '0;
         end else begin
            r_clk <= r_clk + 1'b1;
         end

         case (r_state)
            c_IDLE: begin
               if (send) begin
                  r_snap <= w_guarded;
                  r_idx  <= '0;
               end
            end
            c_START: begin
               if (w_bit_end) begin
                  r_shift <= w_cur_byte;
                  r_bit   <= 3'd0;
               end
            end
            c_DATA: begin
               if (w_bit_end) begin
                  r_shift <= {1'b1, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
               end
            end
            c_STOP: begin
               if (w_bit_end) begin
                  if (w_last_byte) begin
                     r_idx <= '0;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                     for (int i = 0; i < NUM_BYTES - 1; i++) begin
                        r_snap[i] <= r_snap[i+1];
                     end
                     r_snap[NUM_BYTES-1] <= 8'h00;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Requests arriving while a frame is in flight are counted, not queued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop <= 8'h00;
      end else if (send && (r_state != c_IDLE) && (r_drop != 8'hFF)) begin
         r_drop <= r_drop + 8'd1;
      end
   end

   assign txd      = w_txd;
   assign busy     = w_busy;
   assign done     = r_done;
   assign drop_cnt = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_ble_telemetry_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ble_telemetry_tx
// Purpose  : Directed self-checking bench for ble_telemetry_tx at 10 clocks
//            per bit, six payload bytes. Decodes the serial line mid-bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ble_telemetry_tx;

   localparam int CLK_FREQ = 1000;
   localparam int BAUD     = 100;
   localparam int NB       = 6;
   localparam int CPB      = 10;
`ifdef TELEM_CHECKSUM_EN
   localparam int NFB = NB + 2;
`else
   localparam int NFB = NB + 1;
`endif
   localparam int FRAME_CYC = NFB * 10 * CPB;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                send = 1'b0;
   logic [NB-1:0][7:0]  payload = '0;
   logic                txd;
   logic                busy;
   logic                done;
   logic [7:0]          drop_cnt;

   int checks = 0;
   int errors = 0;
   int busy_n;
   int done_n;
   logic [7:0] exp_b [0:7];
   logic [7:0] got_b [0:7];

   ble_telemetry_tx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .NUM_BYTES (NB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .send     (send),
      .payload  (payload),
      .txd      (txd),
      .busy     (busy),
      .done     (done),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) done_n++;
   endtask

   // Expected wire bytes for the current payload.
   task automatic build_exp();
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < NB; i++) begin
         exp_b[i] = (payload[i] == 8'h0A) ? 8'h0B : payload[i];
         x = x ^ exp_b[i];
      end
`ifdef TELEM_CHECKSUM_EN
      exp_b[NB] = (x == 8'h0A) ? 8'h0B : x;
`endif
      exp_b[NFB-1] = 8'h0A;
   endtask

   // Issues a send pulse at the current negedge, decodes the whole frame and
   // returns at the negedge of the done cycle.
   task automatic run_frame(input string tag);
      logic s0, s9;
      logic [7:0] d;
      build_exp();
      send   = 1'b1;
      busy_n = 0;
      done_n = 0;
      @(negedge clk);
      send = 1'b0;
      checks++;
      if (busy !== 1'b1 || txd !== 1'b0) begin
         errors++;
         $display("FAIL %s latency: busy=%b txd=%b expected busy=1 txd=0", tag, busy, txd);
      end
      busy_n = (busy === 1'b1) ? 1 : 0;
      s0 = 1'b1;
      s9 = 1'b0;
      d  = 8'h00;
      for (int b = 0; b < NFB; b++) begin
         for (int k = 0; k < 10; k++) begin
            repeat ((b == 0 && k == 0) ? 5 : 10) step();
            if (k == 0)      s0 = txd;
            else if (k == 9) s9 = txd;
            else             d[k-1] = txd;
         end
         got_b[b] = d;
         checks++;
         if (s0 !== 1'b0 || s9 !== 1'b1) begin
            errors++;
            $display("FAIL %s framing byte %0d: start=%b stop=%b expected start=0 stop=1",
                     tag, b, s0, s9);
         end
         checks++;
         if (d !== exp_b[b]) begin
            errors++;
            $display("FAIL %s data byte %0d: got %02h expected %02h", tag, b, d, exp_b[b]);
         end
      end
      repeat (5) step();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
         errors++;
         $display("FAIL %s completion: done=%b busy=%b txd=%b expected 1 0 1", tag, done, busy, txd);
      end
      checks++;
      if (busy_n !== FRAME_CYC) begin
         errors++;
         $display("FAIL %s busy length: got %0d expected %0d", tag, busy_n, FRAME_CYC);
      end
      checks++;
      if (done_n !== 1) begin
         errors++;
         $display("FAIL %s done pulses: got %0d expected 1", tag, done_n);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || drop_cnt !== 8'h00) begin
         errors++;
         $display("FAIL reset: txd=%b busy=%b done=%b drop=%0d expected 1 0 0 0",
                  txd, busy, done, drop_cnt);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < NB; i++) payload[i] = 8'(i + 1);
      run_frame("basic");
      checks++;
      if (got_b[0] !== 8'h01 || got_b[5] !== 8'h06 || got_b[NFB-1] !== 8'h0A) begin
         errors++;
         $display("FAIL basic bytes: first=%02h sixth=%02h last=%02h expected 01 06 0a",
                  got_b[0], got_b[5], got_b[NFB-1]);
      end
      repeat (3) step();
      checks++;
      if (done !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic idle after: done=%b txd=%b busy=%b expected 0 1 0", done, txd, busy);
      end
   endtask

   task automatic test_newline();
      int first_nl;
      for (int i = 0; i < NB; i++) payload[i] = 8'(8'h30 + i);
      payload[2] = 8'h0A;
      run_frame("newline");
      checks++;
      if (got_b[2] !== 8'h0B) begin
         errors++;
         $display("FAIL newline guard: got %02h expected 0b", got_b[2]);
      end
      first_nl = -1;
      for (int j = NFB - 1; j >= 0; j--) if (got_b[j] == 8'h0A) first_nl = j;
      checks++;
      if (first_nl !== NFB - 1) begin
         errors++;
         $display("FAIL newline packet length: got %0d expected %0d", first_nl, NFB - 1);
      end
   endtask

   task automatic test_busy_reject();
      for (int i = 0; i < NB; i++) payload[i] = 8'(8'hA5 ^ (i * 8'h11));
      fork
         run_frame("reject");
         begin
            repeat (50) @(negedge clk);
            for (int p = 0; p < 3; p++) begin
               send = 1'b1;
               @(negedge clk);
               send = 1'b0;
               repeat (100) @(negedge clk);
            end
         end
      join
      checks++;
      if (drop_cnt !== 8'd3) begin
         errors++;
         $display("FAIL reject count: got %0d expected 3", drop_cnt);
      end
      step();
   endtask

   task automatic test_saturate();
      bit idle_seen;
      send = 1'b1;
      repeat (101) @(negedge clk);
      checks++;
      if (drop_cnt !== 8'd103) begin
         errors++;
         $display("FAIL saturate partial: got %0d expected 103", drop_cnt);
      end
      repeat (200) @(negedge clk);
      send = 1'b0;
      checks++;
      if (drop_cnt !== 8'd255) begin
         errors++;
         $display("FAIL saturate limit: got %0d expected 255", drop_cnt);
      end
      idle_seen = 1'b0;
      for (int c = 0; c < FRAME_CYC + 20 && !idle_seen; c++) begin
         @(negedge clk);
         if (busy === 1'b0) idle_seen = 1'b1;
      end
      checks++;
      if (!idle_seen) begin
         errors++;
         $display("FAIL saturate drain: busy never dropped within %0d cycles", FRAME_CYC + 20);
      end
      step();
   endtask

   task automatic test_snapshot();
      for (int i = 0; i < NB; i++) payload[i] = 8'(8'h11 * (i + 1));
      fork
         run_frame("snapshot");
         begin
            @(negedge clk);
            payload = '1;
         end
      join
      checks++;
      if (got_b[0] !== 8'h11 || got_b[NB-1] !== 8'h66) begin
         errors++;
         $display("FAIL snapshot bytes: first=%02h last=%02h expected 11 66", got_b[0], got_b[NB-1]);
      end
      step();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < NB; i++) payload[i] = 8'(8'hC0 + i);
      run_frame("b2b_first");
      for (int i = 0; i < NB; i++) payload[i] = 8'(8'h5A - i);
      run_frame("b2b_second");
      step();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < NB; i++) payload[i] = 8'(8'hF0 | i);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      repeat (253) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async reset: txd=%b busy=%b expected 1 0", txd, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (drop_cnt !== 8'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL post reset state: drop=%0d done=%b expected 0 0", drop_cnt, done);
      end
      run_frame("after_reset");
      step();
   endtask

`ifdef TELEM_CHECKSUM_EN
   task automatic test_checksum();
      for (int i = 0; i < NB; i++) payload[i] = 8'(8'h10 * (i + 1));
      run_frame("checksum");
      checks++;
      if (got_b[NB] !== 8'h70 || busy_n !== 800) begin
         errors++;
         $display("FAIL checksum: byte=%02h frame=%0d expected 70 800", got_b[NB], busy_n);
      end
      step();
   endtask
`endif

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_basic();
      test_newline();
      test_busy_reject();
      test_saturate();
      test_snapshot();
      test_back_to_back();
      test_async_reset();
`ifdef TELEM_CHECKSUM_EN
      test_checksum();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ble_telemetry_tx.md
Name: ble_telemetry_tx

Overview:
Telemetry return path for the Bluetooth link: snapshots a fixed-length payload of status bytes and serialises it onto the BLE module's UART input as a newline-terminated frame. The frame format matches the command path exactly: raw bytes followed by 0x0A, 8N1, LSB first. It sits at the top level beside the command receiver and drives the line that is currently tied idle-high. The flight-control logic requests a frame with a one-cycle pulse.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ / BAUD (integer division).
NUM_BYTES, 6, payload bytes per frame (1..255).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous reset, active-low.
send  input  1  frame request; sampled each rising edge.
payload  input  [NUM_BYTES-1:0][7:0]  bytes to send; payload[0] goes first.
txd  output  1  serial out to the BLE module's UART RX; idle high.
busy  output  1  high while a frame is in flight.
done  output  1  one-cycle pulse when a frame completes.
drop_cnt  output  8  saturating count of requests rejected because busy was high.

Behaviour:
- Reset (async, rst_n low): txd=1, busy=0, done=0, drop_cnt=0, FSM=IDLE, byte index=0. Asserting reset mid-frame aborts the frame and forces txd high immediately. There is no partial-frame resume.
- Accept: when send=1 in IDLE at a rising edge, the whole payload is latched into an internal snapshot register. From the next cycle, busy=1 and txd=0 (start bit). Later changes on payload do not affect the frame.
- Reject: send=1 while busy=1 is ignored and drop_cnt increments, saturating at 255.
- Frame: snapshot[0]..snapshot[NUM_BYTES-1], then 0x0A. There are no gaps between bytes; the next start bit follows the previous stop bit on the next cycle.
- Newline guard: any payload byte equal to 0x0A is transmitted as 0x0B, so the receiver never sees an early terminator and the frame length seen by the receiver is always NUM_BYTES.
- Bit timing: each bit (start=0, d0..d7 LSB first, stop=1) holds txd for exactly CLKS_PER_BIT cycles.
- FSM states and transitions:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if more bytes remain.
  - STOP -> IDLE after the terminator byte.
- Counters: bit counter 3 bits; byte index wide enough for NUM_BYTES+1 (NUM_BYTES+2 with the optional feature); clk counter $clog2(CLKS_PER_BIT) bits.
- Completion: the cycle after the final stop bit's last clock, busy=0, done=1 for one cycle, txd=1.
  - send=1 in that same cycle is accepted (back-to-back frames). This produces a one-cycle idle-high gap between frames.
- Latency: the start bit appears 1 cycle after send. Total frame time is (NUM_BYTES+1)*10*CLKS_PER_BIT cycles.

Optional Feature:
Macro TELEM_CHECKSUM_EN.
- Defined: one checksum byte is inserted between the last payload byte and 0x0A. It is the XOR of all transmitted payload bytes (after the 0x0B substitution). If the checksum equals 0x0A it is also sent as 0x0B. Frame time becomes (NUM_BYTES+2)*10*CLKS_PER_BIT cycles.
- Undefined: no checksum byte, and no extra logic is compiled.

Test Plan:
Use CLK_FREQ=1000, BAUD=100 (10 clks/bit) and NUM_BYTES=6 unless stated.
1. Basic frame: payload={01,02,03,04,05,06}, send pulse -> txd low at cycle+1; bytes 01..06 then 0A decoded LSB-first at 10 clks/bit; busy high for 700 cycles; a single done pulse; line idle high after.
2. Newline guard: payload[2]=0x0A -> third byte decodes as 0x0B; a loopback through the existing receive chain reports packet_len=6.
3. Busy reject: send pulsed 3 times mid-frame -> frame unaffected and drop_cnt=3. Forcing 256 rejects -> drop_cnt=255 (saturates).
4. Snapshot: payload changed to all 0xFF one cycle after send -> the original bytes are transmitted.
5. Async reset mid-byte: rst_n low during bit d4 of byte 2 -> txd=1 and busy=0 immediately; a new send after release produces a clean full frame.
6. TELEM_CHECKSUM_EN with payload={10,20,30,40,50,60} -> the checksum byte before 0A is 0x70; frame time is 800 cycles.
